data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
//  Data-memory slave on the far end of the memory-stage interface.
//  - Accepts one load/store request at a time: address, store data and a write flag.
//  - Inserts a configurable number of wait states, then performs the array access.
//  - Returns load data with a one-cycle resp_valid pulse.
//  - While a request is in flight, it drives busy so the pipeline can stall stages 1-4.
// PARAMETERS
//  DATA_WIDTH  32  data word width
//  ADDR_WIDTH  10  word-address bits; array depth = 2**ADDR_WIDTH words
//  LATENCY     2   wait states between accept and access, legal range 0..15
// PORTS
//  clk         in   1           rising-edge clock
//  reset       in   1           asynchronous, active-high reset
//  req_valid   in   1           request present
//  req_write   in   1           1 = store, 0 = load
//  addr        in   32          byte address from the memory stage
//  write_data  in   DATA_WIDTH  store data
//  req_ready   out  1           request accepted when req_valid && req_ready
//  busy        out  1           stall request to the pipeline
//  resp_valid  out  1           one-cycle completion pulse, for loads and stores
//  read_data   out  DATA_WIDTH  load result; valid when resp_valid=1
//  err         out  1           misaligned-access flag; driven only with DMEM_ALIGN_CHECK_EN
// BEHAVIOUR
//  Reset and clocking:
//  - One clock, clk. Reset is asynchronous and active-high, port name reset.
//  - Reset values: state=IDLE, cnt=0, resp_valid=0, read_data=0, err=0.
//  - Array contents are not reset.
//  FSM (IDLE -> WAIT -> ACCESS -> RESP):
//  - IDLE: req_ready=1, busy=0.
//    - On accept: latch word index addr[ADDR_WIDTH+1:2], write_data and req_write.
//    - Load cnt=LATENCY.
//    - Next state is WAIT if LATENCY>0, otherwise ACCESS.
//  - WAIT: req_ready=0, busy=1.
//    - cnt decrements each cycle.
//    - At cnt==1, next state is ACCESS.
//  - ACCESS: req_ready=0, busy=1.
//    - Array read or write occurs at this edge; read_data is registered at the same edge.
//    - Next state is RESP.
//  - RESP: resp_valid=1, busy=0, req_ready=1.
//    - An accept in RESP starts the next transaction, so back-to-back requests have no bubble.
//    - Otherwise next state is IDLE.
//  Latency:
//  - Accept edge at cycle T gives resp_valid high during cycle T+LATENCY+2.
//  - Pulse lasts exactly one cycle.
//  Data rules:
//  - Store response: resp_valid pulses; read_data holds its previous value.
//  - Address: addr[1:0] and bits above ADDR_WIDTH+1 are ignored.
//  - Address wrap-around: 0x0000_1000 aliases 0x0 when ADDR_WIDTH=10.
//  Boundary cases:
//  - req_valid with req_ready=0: ignored, not queued.
//    - The requester holds req_valid until accepted.
//  - Reset mid-operation (WAIT or ACCESS):
//    - The transaction is dropped and no response is produced.
//    - A store whose ACCESS edge has not yet occurred leaves the array unmodified.
//  - Inputs change after accept: no effect, because the request was latched at the accept edge.
// CONFIGURATION
//  DMEM_ALIGN_CHECK_EN defined:
//  - An accepted request with addr[1:0]!=0 is checked for alignment.
//  - It still follows the full FSM timing.
//  - No array write occurs for it, and read_data is forced to 0.
//  - err=1 for the RESP cycle only.
//  DMEM_ALIGN_CHECK_EN undefined:
//  - addr[1:0] is ignored and the access proceeds normally.
//  - err is tied to 0.
// STRUCTURE
//  dmem_pkg holds:
//  - the state encoding localparams: IDLE=2'd0, WAIT=2'd1, ACCESS=2'd2, RESP=2'd3;
//  - the default width constants;
//  - the LATENCY counter width, 4 bits.
//  Sub-module dmem_array:
//  - Single-port synchronous RAM, DATA_WIDTH x 2**ADDR_WIDTH.
//  - Ports: clk, we, idx, wdata, rdata; rdata is registered.
//  - No reset.
//  The top level holds the FSM, cnt, request latches and output registers.
// TESTING
//  1. Store then load, LATENCY=2:
//     - Store 0xDEADBEEF to 0x40, then load from 0x40.
//     - read_data=0xDEADBEEF; each resp_valid arrives 4 cycles after its accept edge.
//  2. LATENCY=0:
//     - Load from an address never written after preload 0x12345678.
//     - resp_valid arrives at T+2; busy is high for exactly 1 cycle.
//  3. Back-to-back traffic:
//     - Hold req_valid high for 3 loads, presenting each new request in the RESP cycle.
//     - 3 resp_valid pulses are spaced LATENCY+2 cycles apart, with no idle gap.
//  4. Aliasing:
//     - Store 0xA5A5A5A5 to 0x1000, load from 0x0 with ADDR_WIDTH=10.
//     - Load returns 0xA5A5A5A5.
//  5. Reset during WAIT:
//     - Store 0x11111111 to 0x80, then pulse reset while in WAIT.
//     - No resp_valid; a later load from 0x80 returns the old contents; all outputs are 0 during reset.
//  6. Misaligned access with DMEM_ALIGN_CHECK_EN:
//     - Store to 0x42, then load from 0x40.
//     - err=1 in the store's RESP cycle; the load returns the old word.
//     - Without the macro: err=0 and the store lands at 0x40.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and state encoding for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dmem_pkg;

   localparam int DMEM_DATA_WIDTH = 32;
   localparam int DMEM_ADDR_WIDTH = 10;
   localparam int DMEM_LATENCY    = 2;
   // Wait-state counter width; holds LATENCY values 0..15.
   localparam int DMEM_CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, DATA_WIDTH x 2**ADDR_WIDTH, no reset.
// Latency: write and registered read both take effect at the clock edge.
// Backpressure: none; accepts an access every cycle.
module dmem_array #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] idx,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // Read-first RAM: rdata reflects the word at idx before any same-edge write.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
      rdata <= mem[idx];
   end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory slave: one load/store at a time with LATENCY wait states; optional
// misaligned-access flag when DMEM_ALIGN_CHECK_EN is defined.
// Latency: request presented in cycle T -> resp_valid in cycle T+LATENCY+2, one-cycle pulse.
// Backpressure: req_ready low (busy high) from accept until the response cycle.
module data_memory_responder
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
   parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
   parameter int LATENCY    = DMEM_LATENCY
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   input  logic                  req_write,
   input  logic [31:0]           addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic                  req_ready,
   output logic                  busy,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  err
);

   dmem_state_e           state_q, state_d;
   logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] idx_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rd_q;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic                  write_q;
   logic                  mis_q;
   logic                  mis_w;
   logic                  accept;
   logic                  ram_we;
   logic                  unused_addr;

`ifdef DMEM_ALIGN_CHECK_EN
   assign mis_w       = |addr[1:0];
   assign unused_addr = ^addr[31:ADDR_WIDTH+2];
`else
   assign mis_w       = 1'b0;
   assign unused_addr = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};
`endif

   // Held low during reset so every output reads 0 while reset is asserted.
   assign busy       = (state_q == WAIT) || (state_q == ACCESS);
   assign req_ready  = !busy && !reset;
   assign accept     = req_valid && req_ready;
   assign resp_valid = (state_q == RESP);
   // A misaligned store never touches the array.
   assign ram_we     = (state_q == ACCESS) && write_q && !mis_q;

   dmem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_array (
      .clk   (clk),
      .we    (ram_we),
      .idx   (idx_q),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   // State and wait-state counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; IDLE and RESP both accept so back-to-back requests have no bubble.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, RESP: begin
            if (accept) begin
               cnt_d   = DMEM_CNT_W'(LATENCY);
               state_d = (LATENCY > 0) ? WAIT : ACCESS;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - DMEM_CNT_W'(1);
            if (cnt_q == DMEM_CNT_W'(1)) begin
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            state_d = RESP;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Request latches; later input changes have no effect on the transaction in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q   <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         mis_q   <= 1'b0;
      end else if (accept) begin
         idx_q   <= addr[ADDR_WIDTH+1:2];
         wdata_q <= write_data;
         write_q <= req_write;
         mis_q   <= mis_w;
      end
   end

   // Load data comes straight from the RAM output register in RESP; otherwise the held value.
   always_comb begin
      read_data = rd_q;
      if (state_q == RESP) begin
         if (mis_q) begin
            read_data = '0;
         end else if (!write_q) begin
            read_data = ram_rdata;
         end
      end
   end

   // Hold the last response value once the RAM output moves on to the next request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_q <= '0;
      end else if (state_q == RESP) begin
         rd_q <= read_data;
      end
   end

`ifdef DMEM_ALIGN_CHECK_EN
   logic err_q;

   // Misalignment flag raised for the RESP cycle only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= (state_q == ACCESS) && mis_q;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: LATENCY=2 (dut 0) and LATENCY=0 (dut 1) instances
// checked every cycle against a transaction-level model, plus literal expectations.
// Honours DMEM_ALIGN_CHECK_EN for the misaligned-store expectations.
module tb_data_memory_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rv [2];
   logic        rw [2];
   logic [31:0] ad [2];
   logic [31:0] wd [2];
   logic        rr [2];
   logic        bz [2];
   logic        rsp [2];
   logic        er [2];
   logic [31:0] rd [2];

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   data_memory_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LATENCY(2)) u_dut0 (
      .clk(clk), .reset(reset), .req_valid(rv[0]), .req_write(rw[0]), .addr(ad[0]),
      .write_data(wd[0]), .req_ready(rr[0]), .busy(bz[0]), .resp_valid(rsp[0]),
      .read_data(rd[0]), .err(er[0]));

   data_memory_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LATENCY(0)) u_dut1 (
      .clk(clk), .reset(reset), .req_valid(rv[1]), .req_write(rw[1]), .addr(ad[1]),
      .write_data(wd[1]), .req_ready(rr[1]), .busy(bz[1]), .resp_valid(rsp[1]),
      .read_data(rd[1]), .err(er[1]));

`ifdef DMEM_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   function automatic int lat(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", nm, d, cyc, act, exp);
      end
   endtask

   // ---------------- transaction-level model ----------------
   bit [31:0]   mem [int];
   bit          pend [2], rdue [2], p_w [2], p_mis [2], e_mis [2], known [2];
   int          access_at [2], resp_at [2], free_from [2], p_idx [2];
   logic [31:0] p_dat [2], exp_rd [2];

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            pend[d] = 0; rdue[d] = 0; free_from[d] = 0;
            exp_rd[d] = 32'h0; known[d] = 1;
         end else begin
            if (pend[d] && cyc == access_at[d]) begin
               int key;
               key = d * 1024 + p_idx[d];
               pend[d] = 0; rdue[d] = 1; resp_at[d] = cyc + 1; e_mis[d] = p_mis[d];
               if (p_mis[d]) begin
                  exp_rd[d] = 32'h0; known[d] = 1;
               end else if (p_w[d]) begin
                  mem[key] = p_dat[d];
               end else if (mem.exists(key)) begin
                  exp_rd[d] = mem[key]; known[d] = 1;
               end else begin
                  known[d] = 0;
               end
            end
            if (rv[d] && cyc >= free_from[d]) begin
               pend[d] = 1; p_w[d] = rw[d]; p_idx[d] = int'(ad[d][11:2]); p_dat[d] = wd[d];
               p_mis[d] = ALIGN_EN && (ad[d][1:0] != 2'b00);
               access_at[d] = cyc + lat(d) + 1;
               free_from[d] = cyc + lat(d) + 2;
            end
         end
      end
      cyc++;
   end

   // ---------------- per-cycle compare and monitors ----------------
   int rq0 [$];
   int rq1 [$];
   int bcnt1 = 0;
   int ecnt0 = 0;

   always @(negedge clk) begin
      if (cyc > 0) begin
         for (int d = 0; d < 2; d++) begin
            if (reset) begin
               chk("rst_out", d, {27'h0, rr[d], bz[d], rsp[d], er[d], |rd[d]}, 32'h0);
            end else begin
               bit rdy_e, rsp_e;
               rdy_e = (cyc >= free_from[d]);
               rsp_e = rdue[d] && (cyc == resp_at[d]);
               chk("req_ready", d, {31'h0, rr[d]}, {31'h0, rdy_e});
               chk("busy", d, {31'h0, bz[d]}, {31'h0, !rdy_e});
               chk("resp_valid", d, {31'h0, rsp[d]}, {31'h0, rsp_e});
               chk("err", d, {31'h0, er[d]}, {31'h0, rsp_e && e_mis[d]});
               if (known[d]) chk("read_data", d, rd[d], exp_rd[d]);
            end
         end
         if (!reset && rsp[0]) rq0.push_back(cyc);
         if (!reset && rsp[1]) rq1.push_back(cyc);
         if (bz[1]) bcnt1++;
         if (er[0]) ecnt0++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input int d, input bit w, input logic [31:0] a, input logic [31:0] dat,
                       input bit keep, output int t);
      rv[d] = 1'b1; rw[d] = w; ad[d] = a; wd[d] = dat;
      t = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rr[d]) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) begin
         errors++; checks++;
         $display("FAIL accept_timeout dut%0d: got no req_ready expected accept within 40 cycles", d);
      end
      @(posedge clk); #1;
      if (!keep) rv[d] = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int t, t1, t2, t3;
      for (int d = 0; d < 2; d++) begin
         rv[d] = 0; rw[d] = 0; ad[d] = 0; wd[d] = 0;
      end
      idle(3);
      reset = 1'b0;
      idle(1);
      chk("reset_ready", 0, {31'h0, rr[0]}, 32'h1);
      chk("reset_rdata", 0, rd[0], 32'h0);

      // Store then load at 0x40, LATENCY=2.
      rq0.delete();
      send(0, 1, 32'h40, 32'hDEADBEEF, 0, t); idle(6);
      chk("st_lat", 0, (rq0.size() > 0) ? rq0[0] - t : -1, 4);
      rq0.delete();
      send(0, 0, 32'h40, 32'h0, 0, t); idle(6);
      chk("ld_lat", 0, (rq0.size() > 0) ? rq0[0] - t : -1, 4);
      chk("ld_data", 0, rd[0], 32'hDEADBEEF);

      // LATENCY=0: preload then load.
      rq1.delete();
      send(1, 1, 32'h100, 32'h12345678, 0, t); idle(4);
      chk("l0_st_lat", 1, (rq1.size() > 0) ? rq1[0] - t : -1, 2);
      rq1.delete(); bcnt1 = 0;
      send(1, 0, 32'h100, 32'h0, 0, t); idle(4);
      chk("l0_ld_lat", 1, (rq1.size() > 0) ? rq1[0] - t : -1, 2);
      chk("l0_busy_cycles", 1, bcnt1, 1);
      chk("l0_ld_data", 1, rd[1], 32'h12345678);

      // Preload 0x80, then alias 0x1000 onto word 0.
      send(0, 1, 32'h80, 32'h22222222, 0, t); idle(5);
      send(0, 1, 32'h1000, 32'hA5A5A5A5, 0, t); idle(5);
      send(0, 0, 32'h0, 32'h0, 0, t); idle(5);
      chk("alias_data", 0, rd[0], 32'hA5A5A5A5);

      // Back-to-back loads, valid held high; inputs change while the DUT is waiting.
      rq0.delete();
      send(0, 0, 32'h40, 32'h0, 1, t1);
      send(0, 0, 32'h0, 32'h0, 1, t2);
      send(0, 0, 32'h80, 32'h0, 0, t3);
      idle(6);
      chk("b2b_count", 0, rq0.size(), 3);
      chk("b2b_accept_gap", 0, t2 - t1, 4);
      if (rq0.size() == 3) begin
         chk("b2b_first", 0, rq0[0] - t1, 4);
         chk("b2b_gap1", 0, rq0[1] - rq0[0], 4);
         chk("b2b_gap2", 0, rq0[2] - rq0[1], 4);
      end
      chk("b2b_last_data", 0, rd[0], 32'h22222222);

      // Reset while the store to 0x80 is in WAIT: no response, array untouched.
      rq0.delete();
      send(0, 1, 32'h80, 32'h11111111, 0, t);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_busy", 0, {31'h0, bz[0]}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      idle(6);
      chk("rst_no_resp", 0, rq0.size(), 0);
      send(0, 0, 32'h80, 32'h0, 0, t); idle(5);
      chk("rst_old_data", 0, rd[0], 32'h22222222);

      // Misaligned store to 0x42, then load 0x40.
      ecnt0 = 0;
      send(0, 1, 32'h42, 32'h5555AAAA, 0, t); idle(5);
      chk("mis_err_cycles", 0, ecnt0, ALIGN_EN ? 1 : 0);
      send(0, 0, 32'h40, 32'h0, 0, t); idle(5);
      chk("mis_ld_data", 0, rd[0], ALIGN_EN ? 32'hDEADBEEF : 32'h5555AAAA);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000 time units");
      $fatal(1, "watchdog");
   end

endmodule
